// File: rtl/serial_comp_ctrl.sv
// serial_comp_ctrl: bit-serial unsigned magnitude comparator sequencer.
// Captures two WIDTH-bit operands on start, compares MSB-first through a
// one-bit less/greater/equal chain and pulses done with registered results.
// Optional build macro: COMP_EARLY_EXIT_EN -- finish as soon as the first
// differing bit is seen instead of always walking all WIDTH bits.
module serial_comp_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ready,
  output logic             done,
  output logic             less,
  output logic             greater,
  output logic             equal,
  output logic [15:0]      out
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic             r_wl;
  logic             r_wg;
  logic             r_we;
  logic [CW-1:0]    r_cnt;
  logic             r_less;
  logic             r_greater;
  logic             r_equal;

  logic             w_load;
  logic             w_finish;
  logic             w_end;
  logic             w_a;
  logic             w_b;
  logic             w_wl_nxt;
  logic             w_wg_nxt;
  logic             w_we_nxt;

  // Current bit pair and the updated working flags for this edge
  assign w_a      = r_sa[WIDTH-1];
  assign w_b      = r_sb[WIDTH-1];
  assign w_wl_nxt = r_wl | (r_we & ~w_a &  w_b);
  assign w_wg_nxt = r_wg | (r_we &  w_a & ~w_b);
  assign w_we_nxt = r_we & ~(w_a ^ w_b);

`ifdef COMP_EARLY_EXIT_EN
  assign w_end = (r_cnt == '0) | w_wl_nxt | w_wg_nxt;
`else
  assign w_end = (r_cnt == '0);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_end) begin
          w_finish    = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shift registers, working flags and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa  <= '0;
      r_sb  <= '0;
      r_wl  <= 1'b0;
      r_wg  <= 1'b0;
      r_we  <= 1'b0;
      r_cnt <= '0;
    end else if (w_load) begin
      r_sa  <= a_in;
      r_sb  <= b_in;
      r_wl  <= 1'b0;
      r_wg  <= 1'b0;
      r_we  <= 1'b1;
      r_cnt <= CNT_LOAD;
    end else if (r_state == S_RUN) begin
      r_sa  <= {r_sa[WIDTH-2:0], 1'b0};
      r_sb  <= {r_sb[WIDTH-2:0], 1'b0};
      r_wl  <= w_wl_nxt;
      r_wg  <= w_wg_nxt;
      r_we  <= w_we_nxt;
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Result registers: load only on the edge entering DONE, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_less    <= 1'b0;
      r_greater <= 1'b0;
      r_equal   <= 1'b0;
    end else if (w_finish) begin
      r_less    <= w_wl_nxt;
      r_greater <= w_wg_nxt;
      r_equal   <= w_we_nxt;
    end
  end

  assign ready   = (r_state == S_IDLE);
  assign done    = (r_state == S_DONE);
  assign less    = r_less;
  assign greater = r_greater;
  assign equal   = r_equal;
  assign out     = {15'b0, r_less};

endmodule

// File: tb/tb_serial_comp_ctrl.sv
// Testbench for serial_comp_ctrl: directed and random operand pairs checked
// against plain integer comparison and a latency rule derived from the
// operand bits (honours COMP_EARLY_EXIT_EN when defined for the build).
module tb_serial_comp_ctrl;

  localparam int W = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic          ready;
  logic          done;
  logic          less;
  logic          greater;
  logic          equal;
  logic [15:0]   out;

  int n_checks = 0;
  int n_fail   = 0;

  logic p_less, p_greater, p_equal;

  serial_comp_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .ready   (ready),
    .done    (done),
    .less    (less),
    .greater (greater),
    .equal   (equal),
    .out     (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Edges after the start edge until done is seen
  function automatic int exp_latency(input logic [W-1:0] a, input logic [W-1:0] b);
    int k;
    k = 0;
`ifdef COMP_EARLY_EXIT_EN
    for (int i = W - 1; i >= 0; i--) begin
      if (a[i] != b[i]) return k + 1;
      k++;
    end
`endif
    return W;
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit noisy);
    int g, n, lat;
    logic el, eg, ee;
    g = 0;
    while (!ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("ready_before_start", ready, 1);
    el  = (a < b);
    eg  = (a > b);
    ee  = (a == b);
    lat = exp_latency(a, b);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    @(negedge clk);
    check("ready_low_run", ready, 0);
    check("done_low_run", done, 0);
    n = 0;
    while (n < 3 * W) begin
      start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      a_in  = W'($urandom);
      b_in  = W'($urandom);
      @(negedge clk);
      n++;
      if (done) break;
      check("ready_low_run", ready, 0);
      check("less_hold_run", less, p_less);
      check("greater_hold_run", greater, p_greater);
      check("equal_hold_run", equal, p_equal);
    end
    start = 1'b0;
    check("latency", n, lat);
    check("done_pulse", done, 1);
    check("ready_low_done", ready, 0);
    check("less", less, el);
    check("greater", greater, eg);
    check("equal", equal, ee);
    check("out", out, {15'b0, el});
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("ready_after", ready, 1);
    check("less_hold", less, el);
    check("greater_hold", greater, eg);
    check("equal_hold", equal, ee);
    p_less    = el;
    p_greater = eg;
    p_equal   = ee;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    p_less = 1'b0; p_greater = 1'b0; p_equal = 1'b0;

    // Reset values
    #1;
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_less", less, 0);
    check("rst_greater", greater, 0);
    check("rst_equal", equal, 0);
    check("rst_out", out, 16'h0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("idle_ready", ready, 1);
      check("idle_done", done, 0);
      check("idle_out", out, 16'h0000);
    end

    // Directed pairs
    run_op(16'h1234, 16'h1235, 0);
    run_op(16'h8000, 16'h7FFF, 0);
    run_op(16'hFFFF, 16'hFFFF, 0);
    run_op(16'h0000, 16'h0000, 0);
    run_op(16'h0001, 16'h0000, 0);
    run_op(16'h7FFF, 16'h8000, 0);

    // Single differing bit at every position (exercises early-exit depth)
    for (int i = 0; i < W; i++) begin
      ra = W'($urandom);
      rb = ra ^ (W'(1) << i);
      run_op(ra, rb, 0);
    end

    // Random pairs, with start/operand noise while busy on half of them
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = (i % 5 == 0) ? ra : W'($urandom);
      run_op(ra, rb, (i % 2) == 1);
    end

    // Reset mid-RUN after 7 bit edges
    run_op(16'h0005, 16'h0003, 0);
    start = 1'b1;
    a_in  = 16'h0001;
    b_in  = 16'h0002;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", ready, 1);
    check("midrst_done", done, 0);
    check("midrst_less", less, 0);
    check("midrst_greater", greater, 0);
    check("midrst_equal", equal, 0);
    check("midrst_out", out, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 2) begin
      @(negedge clk);
      check("midrst_no_done", done, 0);
      check("midrst_idle", ready, 1);
    end
    p_less = 1'b0; p_greater = 1'b0; p_equal = 1'b0;
    run_op(16'h0001, 16'h0002, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #200000;
    n_fail++;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
